// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with stall, flush-to-bubble and bubble counter
module id_exe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic        imm_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic [3:0]  status_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic        b_in,
  input  logic        s_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic [11:0] shift_operand_out,
  output logic        imm_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  exe_cmd_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic [3:0]  status_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        wb_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic [15:0] bubble_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic [23:0] signed_imm_24;
    logic [3:0]  exe_cmd;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  status;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
  } stage_t;

  stage_t      stage_d, stage_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      stage_d = '0;
      if (bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else if (!freeze) begin
      // Operand-2 triple (val_rm, shift_operand, imm) is loaded in the same edge as everything else.
      stage_d.valid         = valid_in;
      stage_d.pc            = pc_in;
      stage_d.val_rn        = val_rn_in;
      stage_d.val_rm        = val_rm_in;
      stage_d.shift_operand = shift_operand_in;
      stage_d.imm           = imm_in;
      stage_d.signed_imm_24 = signed_imm_24_in;
      stage_d.exe_cmd       = exe_cmd_in;
      stage_d.dest          = dest_in;
      stage_d.src1          = src1_in;
      stage_d.src2          = src2_in;
      stage_d.status        = status_in;
      // An empty slot must not write, access memory, branch or set flags.
      stage_d.mem_r_en      = mem_r_en_in & valid_in;
      stage_d.mem_w_en      = mem_w_en_in & valid_in;
      stage_d.wb_en         = wb_en_in & valid_in;
      stage_d.b             = b_in & valid_in;
      stage_d.s             = s_in & valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_out         = stage_q.valid;
  assign pc_out            = stage_q.pc;
  assign val_rn_out        = stage_q.val_rn;
  assign val_rm_out        = stage_q.val_rm;
  assign shift_operand_out = stage_q.shift_operand;
  assign imm_out           = stage_q.imm;
  assign signed_imm_24_out = stage_q.signed_imm_24;
  assign exe_cmd_out       = stage_q.exe_cmd;
  assign dest_out          = stage_q.dest;
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;
  assign status_out        = stage_q.status;
  assign mem_r_en_out      = stage_q.mem_r_en;
  assign mem_w_en_out      = stage_q.mem_w_en;
  assign wb_en_out         = stage_q.wb_en;
  assign b_out             = stage_q.b;
  assign s_out             = stage_q.s;
  assign bubble_cnt        = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - scoreboard bench for id_exe_reg
module tb_id_exe_reg;

  logic        clk;
  logic        rst, freeze, flush, valid_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic        imm_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;
  logic        valid_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic        imm_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic [15:0] bubble_cnt;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic [23:0] signed_imm_24;
    logic [3:0]  exe_cmd, dest, src1, src2, status;
    logic        mem_r_en, mem_w_en, wb_en, b, s;
    logic [15:0] cnt;
  } exp_t;

  exp_t model;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  id_exe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm_in(imm_in), .signed_imm_24_in(signed_imm_24_in),
    .exe_cmd_in(exe_cmd_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .status_in(status_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .imm_out(imm_out), .signed_imm_24_out(signed_imm_24_out),
    .exe_cmd_out(exe_cmd_out), .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .status_out(status_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(e.valid));
    chk({tag, ".pc"}, pc_out, e.pc);
    chk({tag, ".val_rn"}, val_rn_out, e.val_rn);
    chk({tag, ".val_rm"}, val_rm_out, e.val_rm);
    chk({tag, ".shift_op"}, 32'(shift_operand_out), 32'(e.shift_operand));
    chk({tag, ".imm"}, 32'(imm_out), 32'(e.imm));
    chk({tag, ".simm24"}, 32'(signed_imm_24_out), 32'(e.signed_imm_24));
    chk({tag, ".exe_cmd"}, 32'(exe_cmd_out), 32'(e.exe_cmd));
    chk({tag, ".dest"}, 32'(dest_out), 32'(e.dest));
    chk({tag, ".src1"}, 32'(src1_out), 32'(e.src1));
    chk({tag, ".src2"}, 32'(src2_out), 32'(e.src2));
    chk({tag, ".status"}, 32'(status_out), 32'(e.status));
    chk({tag, ".ctrl"}, {27'd0, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out},
        {27'd0, e.mem_r_en, e.mem_w_en, e.wb_en, e.b, e.s});
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e.cnt));
  endtask

  // Reference behaviour of one rising edge, computed from the inputs currently driven.
  task automatic model_edge();
    exp_t n;
    n = model;
    if (!rst) begin
      n = '0;
    end else if (flush) begin
      n = '0;
      n.cnt = (model.cnt == 16'hFFFF) ? 16'hFFFF : model.cnt + 16'd1;
    end else if (!freeze) begin
      n.valid = valid_in; n.pc = pc_in; n.val_rn = val_rn_in; n.val_rm = val_rm_in;
      n.shift_operand = shift_operand_in; n.imm = imm_in; n.signed_imm_24 = signed_imm_24_in;
      n.exe_cmd = exe_cmd_in; n.dest = dest_in; n.src1 = src1_in; n.src2 = src2_in;
      n.status = status_in;
      n.mem_r_en = valid_in ? mem_r_en_in : 1'b0;
      n.mem_w_en = valid_in ? mem_w_en_in : 1'b0;
      n.wb_en    = valid_in ? wb_en_in    : 1'b0;
      n.b        = valid_in ? b_in        : 1'b0;
      n.s        = valid_in ? s_in        : 1'b0;
    end
    model = n;
  endtask

  task automatic step(input string tag, input bit do_check);
    exp_t e;
    model_edge();
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (do_check) check_outputs(e, tag);
    end
  endtask

  task automatic rand_inputs();
    valid_in = 1'($urandom); pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    shift_operand_in = 12'($urandom); imm_in = 1'($urandom); signed_imm_24_in = 24'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom); src1_in = 4'($urandom);
    src2_in = 4'($urandom); status_in = 4'($urandom);
    mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom); wb_en_in = 1'($urandom);
    b_in = 1'($urandom); s_in = 1'($urandom);
  endtask

  initial begin
    model = '0;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    rand_inputs();
    step("reset0", 1);
    flush = 1'b1; freeze = 1'b1;
    step("reset1", 1);
    chk("reset_cnt_zero", 32'(bubble_cnt), 32'd0);

    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    rand_inputs();
    pc_in = 32'h0000_0104; val_rm_in = 32'hDEAD_BEEF; shift_operand_in = 12'h0A3;
    imm_in = 1'b1; wb_en_in = 1'b1; valid_in = 1'b1;
    step("load", 1);
    chk("load_pc_const", pc_out, 32'h0000_0104);
    chk("load_rm_const", val_rm_out, 32'hDEAD_BEEF);

    rand_inputs(); valid_in = 1'b1; dest_in = 4'h5;
    step("load_x", 1);
    freeze = 1'b1; rand_inputs(); dest_in = 4'hA;
    for (int i = 0; i < 3; i++) begin
      step("freeze", 1);
      chk("freeze_dest_const", 32'(dest_out), 32'h5);
    end
    freeze = 1'b0;
    step("unfreeze", 1);
    chk("unfreeze_dest_const", 32'(dest_out), 32'hA);

    freeze = 1'b1; flush = 1'b1; wb_en_in = 1'b1; mem_w_en_in = 1'b1; valid_in = 1'b1;
    step("flush_freeze", 1);
    chk("flush_cnt_const", 32'(bubble_cnt), 32'd1);
    freeze = 1'b0; flush = 1'b0;

    rand_inputs(); valid_in = 1'b0; wb_en_in = 1'b1; b_in = 1'b1; val_rn_in = 32'h1234_5678;
    mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; s_in = 1'b1;
    step("invalid_load", 1);
    chk("invalid_rn_const", val_rn_out, 32'h1234_5678);

    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      step("random", 1);
    end

    // Reset asserted mid-freeze, driven low between edges.
    flush = 1'b0; freeze = 1'b0; rand_inputs(); valid_in = 1'b1;
    step("pre_reset_load", 1);
    freeze = 1'b1; rst = 1'b0; flush = 1'b1;
    #2;
    check_outputs(model, "rst_between_edges");
    step("reset_edge", 1);
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; rand_inputs();
    step("after_reset", 1);

    flush = 1'b1;
    while (model.cnt != 16'hFFFE) step("preload", 0);
    chk("preload_cnt", 32'(bubble_cnt), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      step("saturate", 1);
      chk("saturate_const", 32'(bubble_cnt), 32'h0000_FFFF);
    end
    flush = 1'b0; rand_inputs();
    step("sat_load", 1);
    chk("sat_hold_const", 32'(bubble_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 The block SHALL have: clk  in  1  single clock, all state updates on rising edge.
REQ-002 The block SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL have: freeze  in  1  hold all stored state (stall from hazard unit).
REQ-004 The block SHALL have: flush  in  1  replace stage contents with a bubble (taken branch).
REQ-005 The block SHALL have: valid_in  in  1  ID stage holds a real instruction.
REQ-006 The block SHALL have: pc_in  in  32  instruction PC+4.
REQ-007 The block SHALL have: val_rn_in, val_rm_in  in  32 each  register file read data.
REQ-008 The block SHALL have: shift_operand_in  in  12, imm_in  in  1, signed_imm_24_in  in  24  operand-2 and branch fields.
REQ-009 The block SHALL have: exe_cmd_in  in  4, dest_in  in  4, src1_in  in  4, src2_in  in  4, status_in  in  4 (NZCV).
REQ-010 The block SHALL have: mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1 each  control bits.
REQ-011 The block SHALL have one registered output per input field, suffix _out in place of _in, same width, plus valid_out  out  1.
REQ-012 The block SHALL have: bubble_cnt  out  16  count of bubbles inserted by flush since reset.

Function
REQ-013 Every output SHALL be driven directly from a flop; no combinational input-to-output path.
REQ-014 Priority per rising edge SHALL be: reset, then flush, then freeze, then load.
REQ-015 Load (rst=1, flush=0, freeze=0): all _out fields SHALL take their _in values next edge; latency 1 cycle.
REQ-016 Freeze (rst=1, flush=0, freeze=1): all outputs including valid_out and bubble_cnt SHALL hold.
REQ-017 Flush (rst=1, flush=1): valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out SHALL become 0; exe_cmd_out, dest_out, src1_out, src2_out, status_out SHALL become 0; 32-bit and immediate fields SHALL become 0.
REQ-018 Flush with freeze=1 simultaneously SHALL still flush (flush wins).
REQ-019 Load with valid_in=0 SHALL force wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out to 0 regardless of their inputs; data fields load normally.
REQ-020 bubble_cnt SHALL increment by 1 on every edge where flush=1 and rst=1, saturating at 16'hFFFF (no wrap).
REQ-021 imm_out, shift_operand_out and val_rm_out SHALL always be captured in the same edge (never split across cycles), so the downstream operand-2 generator sees a coherent triple.
REQ-022 status_out SHALL be the NZCV captured with the instruction, not live flag state.

Reset
REQ-023 On a rising edge with rst=0, every output including bubble_cnt SHALL become 0, regardless of flush/freeze.
REQ-024 Reset asserted mid-freeze SHALL clear state; first edge after rst returns to 1 SHALL follow REQ-014 normally.
REQ-025 No output SHALL change between edges in response to rst (synchronous only).

Verification
REQ-026 Load: pc_in=32'h0000_0104, val_rm_in=32'hDEAD_BEEF, shift_operand_in=12'h0A3, imm_in=1, wb_en_in=1, valid_in=1 -> one edge later identical values on _out, valid_out=1.
REQ-027 Freeze: load X (dest_in=4'h5), then freeze=1 for 3 edges with dest_in=4'hA -> dest_out stays 4'h5 all 3 cycles, becomes 4'hA on first edge after freeze=0.
REQ-028 Flush+freeze: freeze=1, flush=1, wb_en_in=1, mem_w_en_in=1 -> next edge valid_out=0, wb_en_out=0, mem_w_en_out=0, bubble_cnt increments 0->1.
REQ-029 Invalid load: valid_in=0, wb_en_in=1, b_in=1, val_rn_in=32'h1234_5678 -> wb_en_out=0, b_out=0, val_rn_out=32'h1234_5678, valid_out=0.
REQ-030 Saturation: preload bubble_cnt to 16'hFFFE via flushes, apply 3 more flush edges -> 16'hFFFF, holds.
REQ-031 Reset: loaded state, rst=0 for one edge with flush=1, freeze=1 -> all outputs 0, bubble_cnt 0; rst driven low between edges causes no output change until next edge.
